seq_matrix_multiplier: RTL and testbench
========================================

SEQ_MATRIX_MULTIPLIER -- requirements
Module: seq_matrix_multiplier

Interface
REQ-001 Parameter N, default 4: matrix dimension, N x N; legal range 2..8.
REQ-002 Parameter W, default 4: unsigned element width in bits; legal range 2..16.
REQ-003 Parameter ACCW, default 2*W+$clog2(N): accumulator width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair a_flat/b_flat and sat_en are valid.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a_flat  input  N*N*W  matrix A, row-major; element (r,c) at bits [(r*N+c)*W +: W].
REQ-009 b_flat  input  N*N*W  matrix B, same packing as A.
REQ-010 sat_en  input  1  1 selects saturating result, 0 selects wrap (truncate) result.
REQ-011 out_valid  output  1  c_flat holds a completed product.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 c_flat  output  N*N*W  result C = A x B, same packing.
REQ-014 busy  output  1  high in CALC and DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-016 IDLE: in_ready=1; in_valid=1 at a rising edge SHALL capture a_flat, b_flat and sat_en, clear acc and i, j and k, and enter CALC.
REQ-017 CALC SHALL perform one MAC per cycle: acc <= acc + A[i][k]*B[k][j], full ACCW precision, unsigned.
REQ-018 When k==N-1, the block SHALL write the final sum (acc + product) to C[i][j], clear acc, reset k to 0 and advance j; j wrapping from N-1 to 0 SHALL advance i.
REQ-019 The MAC with i=j=k=N-1 SHALL be the last; the block SHALL then enter DONE.
REQ-020 Latency: out_valid SHALL rise exactly N^3 rising edges after the accepting edge; for N=4 this is 64.
REQ-021 Element result rule, wrap mode (sat_en=0): C[i][j] = sum[W-1:0].
REQ-022 Element result rule, saturating mode (sat_en=1): C[i][j] = 2^W-1 if sum > 2^W-1, else sum.
REQ-023 sat_en SHALL take effect only as captured at acceptance; changes during CALC SHALL be ignored.
REQ-024 DONE: out_valid=1 and c_flat stable; out_ready=1 at an edge SHALL move to IDLE.
REQ-025 Holding out_ready low SHALL hold DONE, c_flat and out_valid indefinitely.
REQ-026 in_ready SHALL be 0 in CALC and DONE; in_valid there SHALL be ignored, with no queuing.
REQ-027 No DONE->IDLE bypass: in_ready SHALL rise one cycle after the out_ready handshake.
REQ-028 c_flat SHALL keep its last value in IDLE until the next job overwrites elements.
REQ-029 Inputs a_flat and b_flat SHALL be don't-care after the accepting edge.
REQ-030 The accumulator SHALL never overflow, because ACCW covers N*(2^W-1)^2.

Reset
REQ-031 reset=1 SHALL immediately, without waiting for clk, force IDLE, in_ready=1, out_valid=0, busy=0, c_flat=0, acc=0 and i=j=k=0.
REQ-032 Reset asserted mid-CALC or in DONE SHALL abort the job with no result delivered; the first edge after release with in_valid=1 SHALL start a new job.

Verification (N=4, W=4)
REQ-033 Reset held 2 cycles -> all outputs at reset values; released with in_valid=0 -> stays IDLE, in_ready=1.
REQ-034 A=identity, B=64'h0123456789ABCDEF, sat_en=0 -> c_flat=64'h0123456789ABCDEF; out_valid rises exactly 64 edges after acceptance, busy high throughout.
REQ-035 A=B=all 4'hF (sum 900) -> sat_en=0 gives every element 4'h4 (c_flat=64'h4444444444444444); sat_en=1 gives 64'hFFFFFFFFFFFFFFFF.
REQ-036 A=all 4'h1, B=all 4'h2, out_ready held low 10 cycles after out_valid -> c_flat=64'h8888888888888888 stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-037 Async reset pulse between clock edges at MAC 30 -> outputs clear before next edge; subsequent job with A=B=0 -> c_flat=0 after 64 edges.
REQ-038 Back-to-back jobs with in_valid held high -> second acceptance occurs exactly one cycle after the first out handshake, sat_en toggled mid-CALC without effect.

Source files
------------

// File: rtl/seq_matrix_multiplier.sv
// -----------------------------------------------------------------------------
// seq_matrix_multiplier
//
// Sequential N x N unsigned matrix multiplier, C = A x B. Each job uses one
// multiply-accumulate per clock cycle, so a job takes N^3 cycles. When a
// result element is written it is either truncated to W bits (wrap) or clamped
// to 2^W-1 (saturate). The saturate/wrap choice is captured when the job is
// accepted.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operands (a_flat, b_flat, sat_en) offered
//   in_ready   block is idle and will accept operands on this edge
//   a_flat     matrix A, row-major, element (r,c) at [(r*N+c)*W +: W]
//   b_flat     matrix B, same packing as A
//   sat_en     1 = saturating result, 0 = wrapping result
//   out_valid  c_flat holds a completed product
//   out_ready  consumer takes the result on this edge
//   c_flat     result matrix C, same packing as A
//   busy       high while computing or holding a result
// -----------------------------------------------------------------------------
module seq_matrix_multiplier #(
    parameter int N    = 4,
    parameter int W    = 4,
    parameter int ACCW = 2 * W + $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] a_flat,
    input  logic [N*N*W-1:0] b_flat,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N*W-1:0] c_flat,
    output logic             busy
);

    localparam int NE   = N * N;
    localparam int IW   = $clog2(N);
    localparam int IDXW = $clog2(NE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Captured operands and result mode for the job in progress.
    logic [N*N*W-1:0] a_reg;
    logic [N*N*W-1:0] b_reg;
    logic             sat_reg;

    // Loop indices: i = result row, j = result column, k = inner-product term.
    logic [IW-1:0]   i_reg, i_next;
    logic [IW-1:0]   j_reg, j_next;
    logic [IW-1:0]   k_reg, k_next;
    logic [ACCW-1:0] acc_reg, acc_next;

    // Element views of the captured operands.
    logic [W-1:0] a_elem [NE];
    logic [W-1:0] b_elem [NE];
    logic [W-1:0] c_elem_reg [NE];

    logic [IDXW-1:0] a_idx;
    logic [IDXW-1:0] b_idx;
    logic [IDXW-1:0] c_idx;

    logic [2*W-1:0]  prod;
    logic [ACCW-1:0] sum;
    logic [W-1:0]    result;

    logic k_last;
    logic last_mac;
    logic accept;
    logic write_elem;

    genvar gi;

    // -------------------------------------------------------------------------
    // Operand unpacking and result packing
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NE; gi++) begin : g_elem
            assign a_elem[gi]            = a_reg[gi*W +: W];
            assign b_elem[gi]            = b_reg[gi*W +: W];
            assign c_flat[gi*W +: W]     = c_elem_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // MAC datapath
    // -------------------------------------------------------------------------
    // A[i][k] sits at row-major index i*N+k, B[k][j] at k*N+j, C[i][j] at i*N+j.
    assign a_idx = IDXW'(i_reg) * IDXW'(N) + IDXW'(k_reg);
    assign b_idx = IDXW'(k_reg) * IDXW'(N) + IDXW'(j_reg);
    assign c_idx = IDXW'(i_reg) * IDXW'(N) + IDXW'(j_reg);

    assign prod = a_elem[a_idx] * b_elem[b_idx];
    assign sum  = acc_reg + ACCW'(prod);

    // ACCW always exceeds W, so any set bit above W-1 means the sum is beyond
    // the largest W-bit value.
    always_comb begin
        result = sum[W-1:0];
        if (sat_reg && (|sum[ACCW-1:W])) begin
            result = '1;
        end
    end

    assign k_last     = (k_reg == IW'(N - 1));
    assign last_mac   = k_last && (i_reg == IW'(N - 1)) && (j_reg == IW'(N - 1));
    assign accept     = (state_reg == IDLE) && in_valid;
    assign write_elem = (state_reg == CALC) && k_last;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (in_valid)  state_next = CALC;
            CALC: if (last_mac)  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Index and accumulator sequencing
    // -------------------------------------------------------------------------
    always_comb begin
        i_next   = i_reg;
        j_next   = j_reg;
        k_next   = k_reg;
        acc_next = acc_reg;
        if (accept) begin
            i_next   = '0;
            j_next   = '0;
            k_next   = '0;
            acc_next = '0;
        end else if (state_reg == CALC) begin
            if (k_last) begin
                // Element finished: restart the inner product for the next one.
                k_next   = '0;
                acc_next = '0;
                if (j_reg == IW'(N - 1)) begin
                    j_next = '0;
                    i_next = (i_reg == IW'(N - 1)) ? '0 : i_reg + IW'(1);
                end else begin
                    j_next = j_reg + IW'(1);
                end
            end else begin
                k_next   = k_reg + IW'(1);
                acc_next = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_reg   <= '0;
            j_reg   <= '0;
            k_reg   <= '0;
            acc_reg <= '0;
        end else begin
            i_reg   <= i_next;
            j_reg   <= j_next;
            k_reg   <= k_next;
            acc_reg <= acc_next;
        end
    end

    // -------------------------------------------------------------------------
    // Operand capture; a_flat, b_flat and sat_en are ignored outside acceptance
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sat_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= a_flat;
            b_reg   <= b_flat;
            sat_reg <= sat_en;
        end
    end

    // -------------------------------------------------------------------------
    // Result elements: each element register loads only when its (i,j) inner
    // product completes, and otherwise keeps the previous job's value.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NE; gi++) begin : g_c_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    c_elem_reg[gi] <= '0;
                end else if (write_elem && (c_idx == IDXW'(gi))) begin
                    c_elem_reg[gi] <= result;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Handshake and status outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_matrix_multiplier
//
// Self-checking bench for seq_matrix_multiplier (N=4, W=4). Directed jobs
// (identity, saturation corners, output back-pressure, reset aborts,
// back-to-back acceptance) plus randomized jobs, each checked against a
// plain triple-loop matrix product with wrap/clamp applied per element.
// -----------------------------------------------------------------------------
module tb_seq_matrix_multiplier;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int DW = N * N * W;
    localparam int LATENCY = N * N * N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a_flat = '0;
    logic [DW-1:0] b_flat = '0;
    logic          sat_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] c_flat;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    seq_matrix_multiplier #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    // Reference: ordinary matrix product, then wrap or clamp each element.
    function automatic logic [DW-1:0] model_mult(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic sat);
        logic [DW-1:0] c;
        int s, ea, eb, lim;
        c   = '0;
        lim = (1 << W) - 1;
        for (int r = 0; r < N; r++) begin
            for (int col = 0; col < N; col++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    ea = int'(a[(r*N+k)*W +: W]);
                    eb = int'(b[(k*N+col)*W +: W]);
                    s += ea * eb;
                end
                if (sat) c[(r*N+col)*W +: W] = W'((s > lim) ? lim : s);
                else     c[(r*N+col)*W +: W] = W'(s % (1 << W));
            end
        end
        return c;
    endfunction

    function automatic logic [DW-1:0] rand_mat();
        return {$urandom, $urandom};
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
    task automatic accept_job(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic s, input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a_flat   = a;
        b_flat   = b;
        sat_en   = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_accepted"}, 64'(busy), 64'd1);
    endtask

    // Counts edges until out_valid while scrambling every don't-care input.
    task automatic run_calc(input string tag);
        int  cyc;
        bit  bad;
        cyc = 0;
        bad = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            a_flat   = rand_mat();
            b_flat   = rand_mat();
            sat_en   = 1'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(LATENCY));
        check({tag, "_calc_status"}, 64'(bad), 64'd0);
    endtask

    // Checks the result, optionally holds out_ready low, then handshakes.
    task automatic finish_job(input logic [DW-1:0] exp, input int hold, input string tag);
        bit bad;
        check({tag, "_c_flat"}, c_flat, exp);
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            a_flat   = rand_mat();
            b_flat   = rand_mat();
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (c_flat !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        if (hold > 0) check({tag, "_hold"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
        check({tag, "_c_kept"}, c_flat, exp);
    endtask

    task automatic do_job(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic s, input int hold, input string tag);
        accept_job(a, b, s, tag);
        run_calc(tag);
        finish_job(model_mult(a, b, s), hold, tag);
    endtask

    initial begin
        logic [DW-1:0] ident, ra, rb, a2, b2;
        logic          rs, s2;

        // Reset held for two cycles
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
        check("rst_c_flat", c_flat, 64'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rel_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);

        // Identity times B gives B
        ident = '0;
        for (int r = 0; r < N; r++) ident[(r*N+r)*W +: W] = W'(1);
        do_job(ident, 64'h0123456789ABCDEF, 1'b0, 0, "ident");
        check("ident_const", c_flat, 64'h0123456789ABCDEF);

        // All-ones-F: sum 900 per element
        do_job({16{4'hF}}, {16{4'hF}}, 1'b0, 0, "allF_wrap");
        check("allF_wrap_const", c_flat, 64'h4444444444444444);
        do_job({16{4'hF}}, {16{4'hF}}, 1'b1, 0, "allF_sat");
        check("allF_sat_const", c_flat, 64'hFFFFFFFFFFFFFFFF);

        // Back-pressure: out_ready low for 10 cycles
        do_job({16{4'h1}}, {16{4'h2}}, 1'b0, 10, "hold");
        check("hold_const", c_flat, 64'h8888888888888888);

        // Randomized jobs
        for (int t = 0; t < 8; t++) begin
            ra = rand_mat();
            rb = rand_mat();
            rs = 1'($urandom);
            do_job(ra, rb, rs, int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
        end

        // Asynchronous reset between edges in the middle of CALC
        accept_job(rand_mat(), rand_mat(), 1'b0, "abort");
        repeat (29) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
        check("abort_c_flat", c_flat, 64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        do_job('0, '0, 1'b0, 0, "zero");

        // Asynchronous reset while holding a result in DONE
        ra = rand_mat();
        rb = rand_mat();
        accept_job(ra, rb, 1'b1, "done_rst");
        run_calc("done_rst");
        check("done_rst_c_flat", c_flat, model_mult(ra, rb, 1'b1));
        #3;
        reset = 1'b1;
        #1;
        check("done_rst_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
        check("done_rst_cleared", c_flat, 64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: in_valid already high during the output handshake
        ra = rand_mat();
        rb = rand_mat();
        do_job(ra, rb, 1'b0, 0, "b2b_pre");
        accept_job(ra, rb, 1'b1, "b2b1");
        run_calc("b2b1");
        check("b2b1_c_flat", c_flat, model_mult(ra, rb, 1'b1));
        a2 = rand_mat();
        b2 = rand_mat();
        s2 = 1'b0;
        a_flat    = a2;
        b_flat    = b2;
        sat_en    = s2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_handshake", {61'd0, out_valid, in_ready, busy}, 64'b010);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_second_accept", 64'(busy), 64'd1);
        run_calc("b2b2");
        finish_job(model_mult(a2, b2, s2), 0, "b2b2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
